// File: rtl/pl_regfile_sb.sv
// Pipelined register file with write-through bypass, trigger flag, debug tap and busy-bit scoreboard.
// Optional macro REGFILE_BYPASS_EN enables the write-through bypass and the same-cycle hazard clear.
module pl_regfile_sb #(
  parameter int WAD      = 5,
  parameter int WD       = 32,
  parameter int TRIG_REG = 5,
  parameter int DBG_REG  = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           RegWrite,
  input  logic [WAD-1:0] AdInReg,
  input  logic [WD-1:0]  DInReg,
  input  logic           TRIGGER,
  input  logic [WAD-1:0] AdOutReg1,
  input  logic [WAD-1:0] AdOutReg2,
  output logic [WD-1:0]  DOutReg1,
  output logic [WD-1:0]  DOutReg2,
  input  logic           IssueValid,
  input  logic [WAD-1:0] IssueRd,
  output logic           Stall,
  output logic [WAD:0]   Pending,
  output logic [WD-1:0]  dbg
);

  localparam int             DEPTH  = 2 ** WAD;
  localparam logic [WAD-1:0] TRIG_A = WAD'(TRIG_REG);
  localparam logic [WAD-1:0] DBG_A  = WAD'(DBG_REG);

  logic [WD-1:0]    regs_q [DEPTH];
  logic [WD-1:0]    regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [WAD:0]     pending_q, pending_d;

  logic wr_en, hazard1, hazard2, issue_acc;

  assign wr_en = RegWrite && (AdInReg != '0);

  // Read ports; address 0 is hard-wired to zero regardless of stored contents.
  always_comb begin
    DOutReg1 = regs_q[AdOutReg1];
    DOutReg2 = regs_q[AdOutReg2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (AdInReg == AdOutReg1)) DOutReg1 = DInReg;
    if (wr_en && (AdInReg == AdOutReg2)) DOutReg2 = DInReg;
`endif
    if (AdOutReg1 == '0) DOutReg1 = '0;
    if (AdOutReg2 == '0) DOutReg2 = '0;
  end

  always_comb begin
`ifdef REGFILE_BYPASS_EN
    hazard1 = busy_q[AdOutReg1] && !(RegWrite && (AdInReg == AdOutReg1));
    hazard2 = busy_q[AdOutReg2] && !(RegWrite && (AdInReg == AdOutReg2));
`else
    hazard1 = busy_q[AdOutReg1];
    hazard2 = busy_q[AdOutReg2];
`endif
  end

  assign Stall     = IssueValid && (hazard1 || hazard2);
  assign issue_acc = IssueValid && !Stall;

  // Writeback clears before issue sets, so a same-cycle reissue keeps the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[AdInReg] = DInReg;
      busy_d[AdInReg] = 1'b0;
    end
    if (TRIGGER) regs_d[TRIG_A] = WD'(1);
    if (issue_acc && (IssueRd != '0)) busy_d[IssueRd] = 1'b1;
    busy_d[0] = 1'b0;
    pending_d = '0;
    for (int i = 0; i < DEPTH; i++) pending_d = pending_d + (WAD+1)'(busy_d[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  assign Pending = pending_q;
  assign dbg     = regs_q[DBG_A];

endmodule

// File: tb/tb_pl_regfile_sb.sv
// Directed self-checking bench for pl_regfile_sb; debug tap moved to register 5 to observe the trigger flag.
// Expected values follow the REGFILE_BYPASS_EN setting of the build.
module tb_pl_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  AdInReg;
  logic [31:0] DInReg;
  logic        TRIGGER;
  logic [4:0]  AdOutReg1, AdOutReg2;
  logic [31:0] DOutReg1, DOutReg2;
  logic        IssueValid;
  logic [4:0]  IssueRd;
  logic        Stall;
  logic [5:0]  Pending;
  logic [31:0] dbg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pl_regfile_sb #(.WAD(5), .WD(32), .TRIG_REG(5), .DBG_REG(5)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .AdInReg(AdInReg), .DInReg(DInReg),
    .TRIGGER(TRIGGER), .AdOutReg1(AdOutReg1), .AdOutReg2(AdOutReg2),
    .DOutReg1(DOutReg1), .DOutReg2(DOutReg2), .IssueValid(IssueValid),
    .IssueRd(IssueRd), .Stall(Stall), .Pending(Pending), .dbg(dbg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 0; AdInReg = 0; DInReg = 0; TRIGGER = 0;
    IssueValid = 0; IssueRd = 0; AdOutReg1 = 0; AdOutReg2 = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    rst = 0;

    // reset state and register 0
    AdOutReg1 = 1; AdOutReg2 = 31; IssueValid = 1; IssueRd = 0; #1;
    chk("rst_dout1", DOutReg1, 0);
    chk("rst_dout2", DOutReg2, 0);
    chk("rst_pending", Pending, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_dbg", dbg, 0);
    idle(); RegWrite = 1; AdInReg = 0; DInReg = 32'hDEAD; AdOutReg1 = 0; #1;
    chk("x0_nobypass", DOutReg1, 0);
    tick(); idle(); #1;
    chk("x0_read", DOutReg1, 0);

    // write and bypass
    RegWrite = 1; AdInReg = 7; DInReg = 32'h12345678; AdOutReg1 = 7; #1;
    chk("wr_bypass", DOutReg1, BYP ? 32'h12345678 : 32'h0);
    tick(); idle(); AdOutReg1 = 7; #1;
    chk("wr_stored", DOutReg1, 32'h12345678);
    chk("wr_pending", Pending, 0);

    // scoreboard RAW on x3
    idle(); IssueValid = 1; IssueRd = 3; #1;
    chk("raw_issue_stall", Stall, 0);
    tick(); idle(); #1;
    chk("raw_pending1", Pending, 1);
    IssueValid = 1; AdOutReg2 = 3; #1;
    chk("raw_stall", Stall, 1);
    tick();
    chk("raw_pending_hold", Pending, 1);
    RegWrite = 1; AdInReg = 3; DInReg = 32'h55; #1;
    chk("raw_wb_stall", Stall, BYP ? 1'b0 : 1'b1);
    chk("raw_wb_dout2", DOutReg2, BYP ? 32'h55 : 32'h0);
    tick(); RegWrite = 0; AdInReg = 0; DInReg = 0; #1;
    chk("raw_after_stall", Stall, 0);
    chk("raw_after_dout2", DOutReg2, 32'h55);
    chk("raw_pending0", Pending, 0);

    // simultaneous issue and writeback on x4
    idle(); IssueValid = 1; IssueRd = 4;
    tick(); idle(); #1;
    chk("sim_pending_a", Pending, 1);
    RegWrite = 1; AdInReg = 4; DInReg = 32'h44; IssueValid = 1; IssueRd = 4; #1;
    chk("sim_stall", Stall, 0);
    tick(); idle(); IssueValid = 1; AdOutReg1 = 4; #1;
    chk("sim_pending_b", Pending, 1);
    chk("sim_still_busy", Stall, 1);
    chk("sim_data", DOutReg1, 32'h44);
    idle(); RegWrite = 1; AdInReg = 4; DInReg = 32'h45;
    tick(); idle(); #1;
    chk("sim_pending_c", Pending, 0);

    // writeback to a non-busy register leaves the count alone
    RegWrite = 1; AdInReg = 9; DInReg = 32'h99;
    tick(); idle(); AdOutReg2 = 9; #1;
    chk("nb_data", DOutReg2, 32'h99);
    chk("nb_pending", Pending, 0);

    // TRIGGER beats a same-cycle write to x5
    idle(); #1;
    chk("trig_dbg_before", dbg, 0);
    TRIGGER = 1; RegWrite = 1; AdInReg = 5; DInReg = 32'hFF; AdOutReg1 = 5; #1;
    chk("trig_bypass", DOutReg1, BYP ? 32'hFF : 32'h0);
    tick(); idle(); AdOutReg1 = 5; #1;
    chk("trig_reg5", DOutReg1, 1);
    chk("trig_dbg", dbg, 1);

    // WAW then reset mid-operation
    idle(); IssueValid = 1; IssueRd = 3;
    tick(); tick(); #1;
    chk("waw_pending", Pending, 1);
    IssueRd = 4;
    tick(); idle(); #1;
    chk("mid_pending2", Pending, 2);
    rst = 1; IssueValid = 1; IssueRd = 6; RegWrite = 1; AdInReg = 7; DInReg = 32'hBAD;
    tick(); rst = 0; idle(); AdOutReg1 = 7; #1;
    chk("mid_rst_pending", Pending, 0);
    chk("mid_rst_x7", DOutReg1, 0);
    chk("mid_rst_dbg", dbg, 0);
    IssueValid = 1; AdOutReg1 = 3; AdOutReg2 = 4; #1;
    chk("mid_rst_nostall", Stall, 0);
    AdOutReg1 = 6; #1;
    chk("mid_rst_x6_free", Stall, 0);
    tick(); idle(); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pl_regfile_sb.md
Name: pl_regfile_sb

Overview:
- Next-generation pipelined register file with an integrated scoreboard.
- Parametrised width and depth; two combinational read ports with write-through bypass; one write port.
- Trigger-driven flag register and a debug tap on a selectable register.
- Per-register busy bits: decode issues a destination, the block stalls dependent issues until writeback and counts in-flight writes.
- Sits between decode (read/issue) and writeback in the pipelined core.

Parameters:
- WAD, 5, address width; depth = 2**WAD registers.
- WD, 32, data width.
- TRIG_REG, 5, register forced to 1 by TRIGGER.
- DBG_REG, 10, register driven onto the dbg output.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- RegWrite  in  1  writeback enable.
- AdInReg  in  WAD  writeback address.
- DInReg  in  WD  writeback data.
- TRIGGER  in  1  force TRIG_REG to 1.
- AdOutReg1  in  WAD  read/source address 1.
- AdOutReg2  in  WAD  read/source address 2.
- DOutReg1  out  WD  read data 1.
- DOutReg2  out  WD  read data 2.
- IssueValid  in  1  decode presents an instruction.
- IssueRd  in  WAD  destination of the issuing instruction.
- Stall  out  1  issue blocked by a source hazard.
- Pending  out  WAD+1  number of busy registers.
- dbg  out  WD  contents of DBG_REG.

Behaviour:
- Reset (rst high at posedge):
  - All registers clear to 0.
  - All busy bits clear; Pending = 0.
  - Outputs follow the cleared state combinationally: DOut* = 0, dbg = 0, Stall = 0.
  - Reset overrides every other input in that cycle, including an in-flight issue or write.
- Register 0:
  - Reads always return 0.
  - Writes to it are dropped.
  - It is never marked busy.
- Write: at posedge, if RegWrite and AdInReg != 0, then reg[AdInReg] <= DInReg.
- TRIGGER: at posedge, reg[TRIG_REG] <= 1. If RegWrite targets TRIG_REG in the same cycle, TRIGGER wins.
- Read: combinational, zero latency.
  - If RegWrite, AdInReg == AdOutRegN and AdInReg != 0, then DOutRegN = DInReg (bypass).
  - Otherwise DOutRegN = reg[AdOutRegN].
  - TRIGGER is not bypassed.
- dbg: mirrors reg[DBG_REG] after update, so it shows the value one cycle after a write.
- Hazard on source N: busy[AdOutRegN] is set and the register is not being written this cycle (RegWrite && AdInReg == AdOutRegN).
- Stall = IssueValid && (hazard on source 1 || hazard on source 2).
- Issue accepted when IssueValid && !Stall. If IssueRd != 0, then busy[IssueRd] <= 1 at posedge.
- Writeback clears busy: RegWrite with AdInReg != 0 sets busy[AdInReg] <= 0.
- Same register issued and written back in the same cycle: set wins, so the register stays busy for the new producer.
- Issue to a register that is already busy (WAW): allowed; the busy bit simply stays set.
- Writeback to a register that is not busy: data is written, busy is unchanged.
- Pending:
  - Registered popcount of the busy bits, updated in the same edge as the busy bits.
  - Range 0..2**WAD-1.
  - Saturation is not required because register 0 is never counted.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass and same-cycle hazard clear as described in Behaviour.
- Undefined:
  - Reads return stored reg[] only.
  - The hazard term ignores the concurrent write, so Stall persists one extra cycle until the written value is visible in reg[].
  - Busy and Pending update timing is unchanged.

Test Plan:
1. Reset then read: rst=1 for 1 cycle, read x1/x31 -> DOut*=0, Pending=0, Stall=0; write x0=0xDEAD -> read x0 = 0.
2. Write and bypass: RegWrite, AdInReg=7, DInReg=0x12345678, AdOutReg1=7 in the same cycle -> DOutReg1=0x12345678 (bypass on) or old value 0 (bypass off); next cycle reads 0x12345678 in both builds.
3. Scoreboard RAW: issue IssueRd=3 -> Pending=1; next cycle IssueValid with AdOutReg2=3 -> Stall=1; writeback x3=0x55 -> Stall=0 that cycle (bypass on) and DOutReg2=0x55; Pending returns to 0.
4. Simultaneous issue and writeback: x4 busy, then RegWrite x4 plus issue IssueRd=4 in the same cycle -> busy[4] stays 1, Pending unchanged at 1.
5. TRIGGER priority: TRIGGER=1 with RegWrite to x5=0xFF -> reg5=1; with DBG_REG=5 override, dbg=1 the next cycle.
6. Reset mid-operation: busy x3,x4 (Pending=2), assert rst -> Pending=0, all busy bits clear, a following issue reading x3 does not stall.
